// File: rtl/aes_128_stream_ctrl.sv
// aes_128_stream_ctrl: credit-gated valid/ready wrapper around the fixed-latency aes_128 core,
// tracking blocks through the core with a valid/tag pipe and buffering results in an output FIFO.
module aes_128_stream_ctrl #(
   parameter int LATENCY = 21,
   parameter int FIFO_DEPTH = 32,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [127:0]       in_state,
   input  logic [127:0]       in_key,
   input  logic [TAG_W-1:0]   in_tag,
   output logic [127:0]       core_state,
   output logic [127:0]       core_key,
   input  logic [127:0]       core_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [127:0]       out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               idle
);
   localparam int aw = $clog2(FIFO_DEPTH);
   localparam logic [aw:0] full = (aw+1)'(FIFO_DEPTH);
   logic acc, pop, wr;
   logic [LATENCY-1:0] vld;
   logic [TAG_W-1:0] tag [LATENCY];
   logic [128+TAG_W-1:0] mem [FIFO_DEPTH];
   logic [aw-1:0] wp, rp;
   logic [aw:0] cnt, occ;
   // occ counts every block between accept and pop, so a capture always finds a free slot
   assign in_ready = !rst & (occ < full);
   assign acc = in_valid & in_ready;
   assign out_valid = cnt != '0;
   assign pop = out_valid & out_ready;
   assign wr = vld[LATENCY-1];
   assign idle = occ == '0;
   assign core_state = acc ? in_state : '0;
   assign core_key = acc ? in_key : '0;
   assign {out_data, out_tag} = out_valid ? mem[rp] : '0;
   always_ff @(posedge clk) begin
      tag[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) tag[i] <= tag[i-1];
      if (wr & !rst) mem[wp] <= {core_out, tag[LATENCY-1]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         occ <= '0;
      end else begin
         vld[0] <= acc;
         for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
         if (wr) wp <= wp + aw'(1);
         if (pop) rp <= rp + aw'(1);
         cnt <= cnt + (aw+1)'(wr) - (aw+1)'(pop);
         occ <= occ + (aw+1)'(acc) - (aw+1)'(pop);
      end
   end
endmodule

// File: doc/aes_128_stream_ctrl.md
# aes_128_stream_ctrl

Streaming controller that sequences the fully pipelined `aes_128` encryption core, which has no valid or enable signals. It accepts (plaintext, key, tag) transactions on a valid/ready input, drives the core's `state`/`key` inputs, and tracks each transaction through the core's fixed latency with a valid/tag shift pipe. It captures each result into an output FIFO and presents it on a valid/ready output. Credit-based admission means a result leaving the core always has a FIFO slot, so nothing is dropped under output backpressure.

## Interface
- `LATENCY`, 21, core latency: edges from core input to valid `out`. Must equal the instantiated core's register depth; ≥1.
- `FIFO_DEPTH`, 32, output FIFO entries and total credits; power of two, ≥2.
- `TAG_W`, 4, width of the user tag carried alongside each block.

Ports:
- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input transaction present.
- `in_ready` output 1: controller can accept this cycle.
- `in_state` input 128: plaintext block.
- `in_key` input 128: cipher key.
- `in_tag` input TAG_W: user tag.
- `core_state` output 128: to `aes_128.state`.
- `core_key` output 128: to `aes_128.key`.
- `core_out` input 128: from `aes_128.out`.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `out_data` output 128: ciphertext.
- `out_tag` output TAG_W: tag of that ciphertext.
- `idle` output 1: nothing in flight and FIFO empty.

## Operation
- Accept: `acc = in_valid & in_ready`. Pop: `pop = out_valid & out_ready`.
- Core drive (combinational):
  - When `acc` is high, `core_state = in_state` and `core_key = in_key`.
  - Otherwise both are 0, which keeps the core's inputs deterministic.
- Track pipe, `LATENCY` stages:
  - Each posedge: `vld[0] <= acc`, `tag[0] <= in_tag`, then `vld[i] <= vld[i-1]`, `tag[i] <= tag[i-1]`.
  - `tag` stages load unconditionally; only `vld` is meaningful.
- Capture: in a cycle where `vld[LATENCY-1]` = 1, `core_out` holds that transaction's result. On the closing edge, write `{core_out, tag[LATENCY-1]}` into the FIFO.
- FIFO:
  - Registered storage with read/write pointers of log2(FIFO_DEPTH) bits that wrap naturally, plus a count of 0..FIFO_DEPTH.
  - `out_valid = (count != 0)`. `out_data`/`out_tag` show the head entry.
  - Head is held stable while `out_valid & !out_ready`.
- Credits: `occ` register, 0..FIFO_DEPTH, counts in-flight plus FIFO-resident transactions.
  - `occ` increments on `acc & !pop`, decrements on `pop & !acc`, and is unchanged on both or neither.
  - `in_ready = !rst & (occ < FIFO_DEPTH)`. It depends only on registers and `rst`, with no combinational path from `out_ready` or `in_valid`.
- Invariant: a FIFO write never occurs with count == FIFO_DEPTH. The bench asserts this.
- Ordering: outputs leave in exact acceptance order.
- `idle = (occ == 0)`.

## Timing
- Reset state:
  - `vld` cleared, FIFO pointers and count 0, `occ` 0.
  - `in_ready` 0 during `rst`, 1 the cycle after.
  - `out_valid` 0, `idle` 1.
  - `out_data`/`out_tag` 0 after reset.
- Latency:
  - Accept in cycle k: result is written at the end of cycle k+LATENCY, and `out_valid` rises in cycle k+LATENCY+1 if the FIFO was empty.
  - Minimum input-to-output latency is LATENCY+1 cycles.
- Throughput: one accept and one pop per cycle sustained while `out_ready` = 1.
- FIFO full and pop in the same cycle: pop frees a slot. If a capture coincides, the write and read both occur and count is unchanged.
- Empty FIFO and capture: the entry is visible the next cycle; there is no bypass.
- Credits exhausted (`occ` == FIFO_DEPTH): `in_ready` = 0. It returns to 1 in the cycle after the first pop.
- Reset mid-operation:
  - All in-flight and FIFO contents are discarded.
  - `core_out` values for discarded transactions that emerge after reset are never captured, because `vld` is cleared.
  - `rst` overrides `acc`, `pop` and capture in the same cycle.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> `out_valid` 0, `in_ready` 0 during reset then 1, `idle` 1, `core_state`/`core_key` 0.
- Single FIPS-197 vector: `in_state` 3243f6a8885a308d313198a2e0370734, `in_key` 2b7e151628aed2a6abf7158809cf4f3c, `in_tag` 5, accepted in cycle 0, `out_ready` 1 -> `out_valid` first high in cycle LATENCY+1 with `out_data` 3925841d02dc09fbdc118597196a0b32, `out_tag` 5, for exactly one cycle; `idle` returns to 1 the next cycle.
- Back-to-back: 8 consecutive accepts with tags 0..7 (vector 1 repeated, alternating with all-zero state/key), `out_ready` 1 -> 8 consecutive `out_valid` cycles starting at LATENCY+1, tags 0..7 in order, ciphertexts matching the golden model (all-zero key/state -> 66e94bd4ef8a2c3b884cfa59ca342b2e).
- Backpressure: `out_ready` 0, `in_valid` 1 continuously -> exactly FIFO_DEPTH accepts, then `in_ready` 0 with no FIFO overflow. Raising `out_ready` drains all FIFO_DEPTH results in order, and `in_ready` returns 1 one cycle after the first pop.
- Simultaneous accept and pop at `occ` = FIFO_DEPTH-1 -> `occ` unchanged, `in_ready` stays 1, no loss or duplication.
- Mid-operation reset: with 5 transactions in flight and 3 in the FIFO, pulse `rst` 1 cycle, then idle LATENCY+5 cycles -> `out_valid` never rises and `idle` 1. A subsequent single vector completes normally with the correct ciphertext.
